// File: rtl/pc_ras_unit.sv
// Program counter for the RAT MCU with an optional return-address stack.
// Define PC_RAS_EN to build the internal RAS; otherwise PC_SEL=1 loads FROM_STACK.
module pc_ras_unit #(
  parameter int          RAS_DEPTH  = 8,
  parameter logic [9:0]  INT_VECTOR = 10'h3FF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PC_LD,
  input  logic       PC_INC,
  input  logic [1:0] PC_SEL,
  input  logic [9:0] FROM_IMMED,
  input  logic [9:0] FROM_STACK,
  input  logic       RAS_PUSH,
  input  logic       RAS_POP,
  output logic [9:0] PC_COUNT,
  output logic [9:0] RAS_TOP,
  output logic       RAS_FULL,
  output logic       RAS_EMPTY,
  output logic       RAS_ERR
);

  logic [9:0] pc_q, pc_d;
  logic [9:0] ret_src;
  logic       err_q, err_d;
  logic       ras_err;

`ifdef PC_RAS_EN
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);

  logic [9:0]    mem_q [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec, wr_ptr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    ret_addr;
  logic          wr_en, empty, full;
  logic          unused_from_stack;

  assign unused_from_stack = ^FROM_STACK;
  assign ret_addr = pc_q + 10'd1;
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(RAS_DEPTH));
  assign ptr_inc  = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ptr_q + PW'(1);
  assign ptr_dec  = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ptr_q - PW'(1);

  // ptr_q always indexes the top entry; a full push simply overwrites the oldest slot.
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_ptr  = ptr_inc;
    ras_err = 1'b0;
    if (RAS_PUSH && RAS_POP && !empty) begin
      wr_en  = 1'b1;
      wr_ptr = ptr_q;
    end else if (RAS_PUSH) begin
      wr_en  = 1'b1;
      wr_ptr = ptr_inc;
      ptr_d  = ptr_inc;
      if (full) ras_err = 1'b1;
      else      cnt_d   = cnt_q + CW'(1);
    end else if (RAS_POP) begin
      if (empty) begin
        ras_err = 1'b1;
      end else begin
        ptr_d = ptr_dec;
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr] <= ret_addr;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign RAS_TOP   = empty ? 10'd0 : mem_q[ptr_q];
  assign RAS_FULL  = full;
  assign RAS_EMPTY = empty;
  assign ret_src   = RAS_TOP;
`else
  logic unused_ras_strobes;

  assign unused_ras_strobes = ^{RAS_PUSH, RAS_POP};
  assign ras_err   = 1'b0;
  assign ret_src   = FROM_STACK;
  assign RAS_TOP   = 10'd0;
  assign RAS_FULL  = 1'b0;
  assign RAS_EMPTY = 1'b1;
`endif

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q | ras_err;
    if (PC_LD) begin
      case (PC_SEL)
        2'd0:    pc_d = FROM_IMMED;
        2'd1:    pc_d = ret_src;
        2'd2:    pc_d = INT_VECTOR;
        default: err_d = 1'b1;
      endcase
    end else if (PC_INC) begin
      pc_d = pc_q + 10'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign PC_COUNT = pc_q;
  assign RAS_ERR  = err_q;

endmodule
